// File: rtl/ps2_mouse_packetizer_pkg.sv
// Shared types, frame constants and bus layout for the PS/2 mouse packetizer.
package ps2_mouse_pkg;

    // Packet assembly state, one state per expected byte
    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } pkt_state_t;

    // PS/2 frame layout: start, 8 data bits LSB first, odd parity, stop
    localparam int unsigned FRAME_BITS  = 11;
    localparam int unsigned PARITY_BIT  = 9;
    localparam int unsigned LAST_BIT    = FRAME_BITS - 1;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

    // Status byte bit positions
    localparam int unsigned SYNC_BIT = 3;
    localparam int unsigned XSIGN    = 4;
    localparam int unsigned YSIGN    = 5;
    localparam int unsigned XOVF     = 6;
    localparam int unsigned YOVF     = 7;

    // ps2_mouse bus field offsets
    localparam int unsigned STATUS_LSB = 0;
    localparam int unsigned DX_LSB     = 8;
    localparam int unsigned DY_LSB     = 16;
    localparam int unsigned TOGGLE     = 24;
    localparam int unsigned MOUSE_W    = 25;

    // Clamp a 9-bit {sign,delta} movement to its extreme when the overflow flag is set
    function automatic logic [7:0] sat_delta(input logic ovf, input logic sign, input logic [7:0] raw);
        if (!ovf) begin
            return raw;
        end
        return sign ? 8'h00 : 8'hFF;
    endfunction

endpackage

// File: rtl/ps2_mouse_packetizer_if.sv
// PS/2 pin inputs and packetized mouse bus outputs of the packetizer.
interface ps2_mouse_packetizer_if;
    import ps2_mouse_pkg::*;

    logic                 ps2_clk;
    logic                 ps2_data;
    logic [MOUSE_W-1:0]   ps2_mouse;
    logic                 frame_err;
    logic                 sync_err;

    // Board/pin side: drives the PS/2 lines, observes the packet bus
    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_mouse,
        input  frame_err,
        input  sync_err
    );

    // Packetizer side
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_mouse,
        output frame_err,
        output sync_err
    );

endinterface

// File: rtl/ps2_mouse_packetizer_rx_byte.sv
// PS/2 byte receiver: pin synchronizers, clock glitch filter, 11-bit framing,
// odd-parity check and mid-frame bit timeout.
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 10000
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(BIT_TIMEOUT + 1);
    localparam int unsigned CW = $clog2(FRAME_BITS);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_f, r_clk_f_d;
    logic [FW-1:0] r_filt_cnt;
    logic [CW-1:0] r_bit_cnt;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_shift;
    logic          r_start, r_parity;
    logic          r_byte_valid, r_frame_err;
    logic [7:0]    r_byte;
    logic          w_fall;

    // Two-flop synchronizers; lines idle high
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows the pin only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_clk_f    <= 1'b1;
            r_clk_f_d  <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_f    <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    // Frame shifter, end-of-frame validation and bit timeout
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt    <= '0;
            r_timer      <= '0;
            r_shift      <= '0;
            r_start      <= 1'b0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_timer <= '0;
                if (r_bit_cnt == CW'(LAST_BIT)) begin
                    r_bit_cnt <= '0;
                    if ((r_start == START_LEVEL) && (^{r_shift, r_parity}) && (r_dat_s2 == STOP_LEVEL)) begin
                        r_byte_valid <= 1'b1;
                        r_byte       <= r_shift;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == '0) begin
                        r_start <= r_dat_s2;
                    end else if (r_bit_cnt == CW'(PARITY_BIT)) begin
                        r_parity <= r_dat_s2;
                    end else begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                    end
                end
            end else if (r_bit_cnt != '0) begin
                if (r_timer == TW'(BIT_TIMEOUT - 1)) begin
                    r_frame_err <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_timer     <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_mouse_packetizer.sv
// Assembles received PS/2 bytes into 3-byte mouse packets on the toggle-strobed bus.
module ps2_mouse_packetizer
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned BIT_TIMEOUT = 10000,
    parameter int unsigned PKT_TIMEOUT = 1000000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    ps2_mouse_packetizer_if.slave  bus
);

    localparam int unsigned PW = $clog2(PKT_TIMEOUT + 1);

    logic               w_byte_valid;
    logic [7:0]         w_byte;
    logic               w_frame_err;

    pkt_state_t         r_state;
    logic [7:0]         r_b0, r_b1;
    logic [PW-1:0]      r_pkt_timer;
    logic [MOUSE_W-1:0] r_mouse;
    logic               r_sync_err;

    ps2_rx_byte #(
        .FILTER_LEN  (FILTER_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_rx (
        .i_clk_sys    (clk_sys),
        .i_reset      (reset),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_data   (bus.ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    // Packet FSM with resync on frame error / packet timeout and registered commit
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= WAIT_B0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_pkt_timer <= '0;
            r_mouse     <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            case (r_state)
                WAIT_B0: begin
                    r_pkt_timer <= '0;
                    if (w_byte_valid) begin
                        if (w_byte[SYNC_BIT]) begin
                            r_b0    <= w_byte;
                            r_state <= WAIT_B1;
                        end else begin
                            r_sync_err <= 1'b1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    if (w_byte_valid) begin
                        r_pkt_timer <= '0;
                        if (r_state == WAIT_B1) begin
                            r_b1    <= w_byte;
                            r_state <= WAIT_B2;
                        end else begin
                            r_mouse <= {~r_mouse[TOGGLE],
                                        sat_delta(r_b0[YOVF], r_b0[YSIGN], w_byte),
                                        sat_delta(r_b0[XOVF], r_b0[XSIGN], r_b1),
                                        r_b0};
                            r_state <= WAIT_B0;
                        end
                    end else if (w_frame_err || (r_pkt_timer == PW'(PKT_TIMEOUT - 1))) begin
                        r_pkt_timer <= '0;
                        r_state     <= WAIT_B0;
                    end else begin
                        r_pkt_timer <= r_pkt_timer + 1'b1;
                    end
                end
                default: begin
                    r_pkt_timer <= '0;
                    r_state     <= WAIT_B0;
                end
            endcase
        end
    end

    assign bus.ps2_mouse = r_mouse;
    assign bus.frame_err = w_frame_err;
    assign bus.sync_err  = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Directed + randomized bench for ps2_mouse_packetizer against a byte-level packet model.
module tb_ps2_mouse_packetizer;

    localparam int unsigned FILT = 8;
    localparam int unsigned BTO  = 200;
    localparam int unsigned PTO  = 3000;
    localparam int unsigned HALF = 20;
    localparam int unsigned GAP  = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_mouse_packetizer_if bus_if ();

    ps2_mouse_packetizer #(
        .FILTER_LEN  (FILT),
        .BIT_TIMEOUT (BTO),
        .PKT_TIMEOUT (PTO)
    ) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Observed event counters
    int   cyc    = 0;
    int   bv_cyc = -100;
    int   n_frame = 0, n_sync = 0, n_flip = 0;
    logic prev_tog = 1'b0;

    // Reference model state
    int          m_phase = 0;
    logic [7:0]  m_b0 = '0, m_b1 = '0;
    logic [24:0] m_mouse = '0;
    int          e_frame = 0, e_sync = 0, e_flip = 0;

    // Pulse counting and commit latency (toggle must move one cycle after the last byte_valid)
    always @(negedge clk) begin
        cyc++;
        if (dut.u_rx.o_byte_valid) bv_cyc = cyc;
        if (!rst) begin
            if (bus_if.frame_err) n_frame++;
            if (bus_if.sync_err)  n_sync++;
            if (bus_if.ps2_mouse[24] !== prev_tog) begin
                n_flip++;
                checks++;
                assert (cyc - bv_cyc == 1) else begin
                    errors++;
                    $error("FAIL commit_latency observed=%0d expected=1", cyc - bv_cyc);
                end
            end
        end
        prev_tog = bus_if.ps2_mouse[24];
    end

    // 9-bit signed movement, clamped to +255/-256 on overflow, returned as its low byte
    function automatic logic [7:0] sat_ref(input logic ovf, input logic sign, input logic [7:0] raw);
        int v;
        v = sign ? int'(raw) - 256 : int'(raw);
        if (ovf) v = sign ? -256 : 255;
        return 8'(v);
    endfunction

    task automatic mdl_byte(input logic [7:0] b);
        case (m_phase)
            0: if (b[3]) begin m_b0 = b; m_phase = 1; end else e_sync++;
            1: begin m_b1 = b; m_phase = 2; end
            default: begin
                m_mouse = {~m_mouse[24], sat_ref(m_b0[7], m_b0[5], b),
                           sat_ref(m_b0[6], m_b0[4], m_b1), m_b0};
                e_flip++;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic mdl_frame_err();
        e_frame++;
        m_phase = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_mouse"}, 32'(bus_if.ps2_mouse), 32'(m_mouse));
        chk({tag, "_frame_err_cnt"}, 32'(n_frame), 32'(e_frame));
        chk({tag, "_sync_err_cnt"}, 32'(n_sync), 32'(e_sync));
        chk({tag, "_toggle_cnt"}, 32'(n_flip), 32'(e_flip));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic d);
        bus_if.ps2_data = d;
        wait_cyc(HALF);
        bus_if.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus_if.ps2_clk = 1'b1;
    endtask

    // One PS/2 frame; optional parity corruption and a short clock glitch before bit glitch_bit
    task automatic send_raw(input logic [7:0] b, input logic bad_par, input int glitch_bit);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_bit) begin
                bus_if.ps2_data = fr[i];
                wait_cyc(5);
                bus_if.ps2_clk = 1'b0;
                wait_cyc(5);
                bus_if.ps2_clk = 1'b1;
            end
            ps2_bit(fr[i]);
        end
        bus_if.ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_raw(b, 1'b0, -1);
        mdl_byte(b);
    endtask

    task automatic send_bad(input logic [7:0] b);
        send_raw(b, 1'b1, -1);
        mdl_frame_err();
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] dx, input logic [7:0] dy);
        send_ok(b0);
        send_ok(dx);
        send_ok(dy);
    endtask

    initial begin
        logic [7:0] rb0, rdx, rdy;
        int bad_pos;

        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        wait_cyc(5);
        @(negedge clk);
        chk("reset_mouse", 32'(bus_if.ps2_mouse), 32'h0);
        chk("reset_frame_err", 32'(bus_if.frame_err), 32'h0);
        chk("reset_sync_err", 32'(bus_if.sync_err), 32'h0);
        rst = 1'b0;
        wait_cyc(5);

        // Basic packet
        send_pkt(8'h08, 8'h05, 8'hFD);
        chk("pkt1_const", 32'(bus_if.ps2_mouse), 32'h1FD0508);
        check_all("pkt1");

        // Out-of-sync leading byte
        send_ok(8'h00);
        send_pkt(8'h09, 8'h03, 8'h02);
        check_all("sync");

        // Parity error mid-packet discards the partial packet
        send_ok(8'h08);
        send_bad(8'h12);
        send_pkt(8'h18, 8'h7F, 8'h80);
        check_all("parity");

        // Overflow saturation: X positive/negative, Y positive/negative
        send_pkt(8'h48, 8'h10, 8'h01);
        chk("xovf_pos_dx", 32'(bus_if.ps2_mouse[15:8]), 32'hFF);
        check_all("xovf_pos");
        send_pkt(8'h5C, 8'h10, 8'h01);
        chk("xovf_neg_dx", 32'(bus_if.ps2_mouse[15:8]), 32'h00);
        check_all("xovf_neg");
        send_pkt(8'h88, 8'h22, 8'h33);
        check_all("yovf_pos");
        send_pkt(8'hA8, 8'h22, 8'h33);
        check_all("yovf_neg");

        // Packet timeout drops stale bytes
        send_ok(8'h08);
        send_ok(8'h01);
        wait_cyc(PTO + 10);
        m_phase = 0;
        send_pkt(8'h28, 8'h01, 8'h02);
        check_all("pkt_timeout");

        // Short clock glitch is filtered out
        send_raw(8'h09, 1'b0, 4);
        mdl_byte(8'h09);
        send_pkt(8'h33, 8'h44, 8'h2B);
        check_all("glitch");

        // Bit timeout after four bits, then normal packet
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        bus_if.ps2_data = 1'b1;
        wait_cyc(BTO + 20);
        mdl_frame_err();
        check_all("bit_timeout");
        send_pkt(8'h08, 8'h11, 8'h22);
        check_all("after_timeout");

        // Async reset mid-packet
        send_ok(8'h08);
        send_ok(8'h01);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        rst = 1'b0;
        m_phase = 0;
        m_mouse = '0;
        wait_cyc(5);
        check_all("reset_mid");
        send_ok(8'h03);
        send_pkt(8'h08, 8'h11, 8'h22);
        check_all("after_reset");

        // Randomized packets with occasional sync junk and parity errors
        for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 4) == 0) send_ok(8'($urandom_range(0, 255)) & 8'hF7);
            rb0 = 8'($urandom_range(0, 255)) | 8'h08;
            rdx = 8'($urandom_range(0, 255));
            rdy = 8'($urandom_range(0, 255));
            bad_pos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1;
            if (bad_pos == 0) send_bad(rb0); else send_ok(rb0);
            if (bad_pos == 1) send_bad(rdx); else send_ok(rdx);
            if (bad_pos == 2) send_bad(rdy); else send_ok(rdy);
            check_all($sformatf("rand%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
